// File: rtl/vram_text_writer_if.sv
// rtl/vram_text_writer_if.sv - Wishbone-like bus bundle between a CPU master and the text VRAM writer
// Signals: W_ADDR/W_DAT_I/W_WE/W_STB driven by the master; W_DAT_O/W_ACK driven by the slave.
interface vram_text_writer_if;
    logic [31:0] W_ADDR;
    logic [31:0] W_DAT_I;
    logic        W_WE;
    logic        W_STB;
    logic [31:0] W_DAT_O;
    logic        W_ACK;

    modport master (
        output W_ADDR, W_DAT_I, W_WE, W_STB,
        input  W_DAT_O, W_ACK
    );

    modport slave (
        input  W_ADDR, W_DAT_I, W_WE, W_STB,
        output W_DAT_O, W_ACK
    );
endinterface

// File: rtl/vram_text_writer.sv
// rtl/vram_text_writer.sv - bus-side writer for the character VRAM with auto-increment cursor and screen clear
// Ports: clk, W_RST (async active-high), bus (slave modport: address/data/strobe/ack),
//        vram_addr/vram_data/vram_we (write-only VRAM port B).
module vram_text_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 W_RST,
    vram_text_writer_if.slave    bus,
    output logic [ADDR_W-1:0]    vram_addr,
    output logic [DATA_W-1:0]    vram_data,
    output logic                 vram_we
);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CURSOR = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cursor;
    logic [1:0]        reg_sel;
    logic              sel;
    logic              busy;
    logic              stall;
    logic              accept;
    logic              start_clear;
    logic              clear_done;
    logic              data_write;
    logic              cursor_write;
    logic [DATA_W-1:0] fill;
    logic [31:0]       rdata;

    assign reg_sel = bus.W_ADDR[3:2];
    assign sel     = (bus.W_ADDR[31:4] == BASE_ADDR[31:4]);
    assign busy    = (state == CLEAR);

    // DATA/CURSOR writes would race the fill, so they wait (unacked) until the clear ends.
    assign stall  = busy && bus.W_WE && ((reg_sel == REG_DATA) || (reg_sel == REG_CURSOR));
    // Gating on W_ACK gives the mandatory idle cycle after each acknowledge.
    assign accept = bus.W_STB && !bus.W_ACK && sel && !stall;

    assign data_write   = accept && bus.W_WE && (reg_sel == REG_DATA);
    assign cursor_write = accept && bus.W_WE && (reg_sel == REG_CURSOR);
    assign start_clear  = accept && bus.W_WE && (reg_sel == REG_CTRL) && bus.W_DAT_I[0] && !busy;
    // vram_addr already holds the cell being written this cycle during a clear.
    assign clear_done   = busy && (vram_addr == {ADDR_W{1'b1}});
    assign fill         = DATA_W'(bus.W_DAT_I[31:16]);

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA, REG_CURSOR: rdata[ADDR_W-1:0] = cursor;
            REG_CTRL:             rdata[0]          = busy;
            default:              rdata             = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_clear) state_next = CLEAR;
            CLEAR: if (clear_done)  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge W_RST) begin
        if (W_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge W_RST) begin
        if (W_RST) begin
            bus.W_ACK   <= 1'b0;
            bus.W_DAT_O <= '0;
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_data   <= '0;
            cursor      <= '0;
        end else begin
            bus.W_ACK <= accept;
            vram_we   <= 1'b0;
            if (accept) begin
                bus.W_DAT_O <= rdata;
            end
            if (data_write) begin
                vram_we   <= 1'b1;
                vram_addr <= cursor;
                vram_data <= bus.W_DAT_I[DATA_W-1:0];
                cursor    <= cursor + 1'b1;
            end
            if (cursor_write) begin
                cursor <= bus.W_DAT_I[ADDR_W-1:0];
            end
            if (start_clear) begin
                vram_we   <= 1'b1;
                vram_addr <= '0;
                vram_data <= fill;
            end
            if (busy) begin
                if (clear_done) begin
                    cursor <= '0;
                end else begin
                    vram_we   <= 1'b1;
                    vram_addr <= vram_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_text_writer.sv
// tb/tb_vram_text_writer.sv - self-checking bench for vram_text_writer against a queue-based reference model
module tb_vram_text_writer;
    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_CUR  = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_RSVD = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;
    longint      cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [25:0] log_q[$];
    longint      logc_q[$];
    logic [25:0] exp_q[$];
    int          cur_m;

    vram_text_writer_if bus_if ();

    vram_text_writer #(.BASE_ADDR(32'h0), .ADDR_W(10), .DATA_W(16)) dut (
        .clk       (clk),
        .W_RST     (rst),
        .bus       (bus_if),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_we   (vram_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            log_q.push_back({vram_addr, vram_data});
            logc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_op(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdat, input int budget,
                          output logic [31:0] rdat, output int lat, output longint ackc);
        logic got;
        got = 1'b0; rdat = '0; lat = 0; ackc = -1;
        bus_if.W_ADDR = addr; bus_if.W_WE = we; bus_if.W_DAT_I = wdat; bus_if.W_STB = 1'b1;
        while (!got && lat < budget) begin
            @(posedge clk); #1;
            lat++;
            if (bus_if.W_ACK === 1'b1) begin
                got = 1'b1; rdat = bus_if.W_DAT_O; ackc = cyc;
                if (we && addr[3:2] == 2'd0) chk({tag, " vram_we"}, 64'(vram_we), 64'(1'b1));
            end
        end
        bus_if.W_STB = 1'b0; bus_if.W_WE = 1'b0;
        chk({tag, " ack"}, 64'(got), 64'(1'b1));
        @(posedge clk); #1;
        chk({tag, " ack_drop"}, 64'(bus_if.W_ACK), 64'(1'b0));
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdat, output longint ackc);
        logic [31:0] r;
        int lat;
        bus_op(tag, addr, 1'b1, wdat, 4, r, lat, ackc);
        chk({tag, " latency"}, 64'(lat), 64'(1));
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, output logic [31:0] r);
        int lat;
        longint ac;
        bus_op(tag, addr, 1'b0, 32'h0, 4, r, lat, ac);
        chk({tag, " latency"}, 64'(lat), 64'(1));
    endtask

    function automatic void m_data(input logic [31:0] d);
        logic [9:0] a;
        a = 10'(cur_m);
        exp_q.push_back({a, d[15:0]});
        cur_m = (cur_m + 1) % 1024;
    endfunction

    function automatic void m_clear(input logic [15:0] f);
        for (int i = 0; i < 1024; i++) exp_q.push_back({10'(i), f});
        cur_m = 0;
    endfunction

    task automatic check_log(input string tag);
        int n;
        chk({tag, " log_size"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (log_q[i] !== exp_q[i]) chk($sformatf("%s entry%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
        end
        if (n > 0) chk({tag, " last_entry"}, 64'(log_q[n-1]), 64'(exp_q[n-1]));
        log_q.delete(); logc_q.delete(); exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] r;
        int it;
        it = 0;
        r = 32'h1;
        while (r !== 32'h0 && it < 800) begin
            rd({tag, " poll"}, A_CTRL, r);
            it++;
        end
        chk({tag, " idle"}, 64'(r), 64'h0);
    endtask

    task automatic check_fill_timing(input string tag, input longint ackc);
        longint first_c, last_c;
        first_c = (logc_q.size() > 0) ? logc_q[0] : -1;
        last_c  = (logc_q.size() >= 1024) ? logc_q[1023] : -1;
        chk({tag, " first_cycle"}, 64'(first_c), 64'(ackc));
        chk({tag, " last_cycle"}, 64'(last_c), 64'(ackc + 1023));
    endtask

    initial begin
        logic [31:0] r, d;
        longint ac, ac2;
        int lat, acks, sel;
        logic [15:0] f;

        bus_if.W_ADDR = '0; bus_if.W_DAT_I = '0; bus_if.W_WE = 1'b0; bus_if.W_STB = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ack", 64'(bus_if.W_ACK), 64'(1'b0));
        chk("rst dat_o", 64'(bus_if.W_DAT_O), 64'h0);
        chk("rst vram_we", 64'(vram_we), 64'(1'b0));
        chk("rst vram_addr", 64'(vram_addr), 64'h0);
        chk("rst vram_data", 64'(vram_data), 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        cur_m = 0;
        rd("rst cursor", A_DATA, r);
        chk("rst cursor val", 64'(r), 64'h0);

        wr("cur5", A_CUR, 32'd5, ac); cur_m = 5;
        wr("d41", A_DATA, 32'h41, ac); m_data(32'h41);
        wr("d42", A_DATA, 32'h42, ac); m_data(32'h42);
        rd("rd7", A_DATA, r);
        chk("rd7 val", 64'(r), 64'd7);
        check_log("t1");

        wr("cur1023", A_CUR, 32'd1023, ac); cur_m = 1023;
        wr("d58", A_DATA, 32'h58, ac); m_data(32'h58);
        wr("d59", A_DATA, 32'h59, ac); m_data(32'h59);
        rd("rd1", A_CUR, r);
        chk("rd1 val", 64'(r), 64'd1);
        check_log("t2");

        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                wr("rnd cur", A_CUR, d, ac); cur_m = d % 1024;
            end else begin
                wr("rnd data", A_DATA, d, ac); m_data(d);
            end
            rd("rnd rd", ($urandom_range(0, 1) == 0) ? A_DATA : A_CUR, r);
            chk("rnd cursor", 64'(r), 64'(cur_m));
        end
        check_log("rnd");

        wr("rsvd wr", A_RSVD, $urandom, ac);
        rd("rsvd rd", A_RSVD, r);
        chk("rsvd val", 64'(r), 64'h0);
        wr("ctrl0", A_CTRL, 32'hABCD_0000, ac);
        rd("ctrl0 rd", A_CTRL, r);
        chk("ctrl0 busy", 64'(r), 64'h0);
        rd("noeff cur", A_CUR, r);
        chk("noeff cur val", 64'(r), 64'(cur_m));
        check_log("noeff");

        wr("clr", A_CTRL, 32'h0020_0001, ac); m_clear(16'h0020);
        rd("clr busy", A_CTRL, r);
        chk("clr busy val", 64'(r), 64'h1);
        wr("clr restart", A_CTRL, 32'h7777_0001, ac2);
        wait_idle("clr");
        rd("clr cur", A_CUR, r);
        chk("clr cur val", 64'(r), 64'h0);
        check_fill_timing("clr", ac);
        check_log("clr");

        f = 16'($urandom);
        d = $urandom;
        wr("clr2", A_CTRL, {f, 16'h0001}, ac); m_clear(f);
        bus_op("stall data", A_DATA, 1'b1, d, 2000, r, lat, ac2);
        chk("stall ack cycle", 64'(ac2), 64'(ac + 1025));
        m_data(d);
        rd("stall cur", A_CUR, r);
        chk("stall cur val", 64'(r), 64'h1);
        check_log("stall");

        f = 16'($urandom);
        wr("clr3", A_CTRL, {f, 16'h0001}, ac);
        acks = 0;
        while (!(vram_we === 1'b1 && vram_addr === 10'd300) && acks < 2000) begin
            @(negedge clk); acks++;
        end
        chk("reach300", 64'(vram_addr), 64'd300);
        #1 rst = 1'b1;
        #1;
        chk("mid rst we", 64'(vram_we), 64'(1'b0));
        chk("mid rst addr", 64'(vram_addr), 64'h0);
        chk("mid rst data", 64'(vram_data), 64'h0);
        chk("mid rst ack", 64'(bus_if.W_ACK), 64'(1'b0));
        chk("mid rst dat_o", 64'(bus_if.W_DAT_O), 64'h0);
        log_q.delete(); logc_q.delete(); exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post rst writes", 64'(log_q.size()), 64'd0);
        cur_m = 0;
        f = 16'($urandom);
        wr("clr4", A_CTRL, {f, 16'h0001}, ac); m_clear(f);
        wait_idle("clr4");
        check_fill_timing("clr4", ac);
        check_log("clr4");

        wr("pre6 cur", A_CUR, 32'd77, ac); cur_m = 77;
        bus_if.W_ADDR = 32'h10; bus_if.W_WE = 1'b1; bus_if.W_DAT_I = 32'h1; bus_if.W_STB = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus_if.W_ACK === 1'b1) acks++;
        end
        bus_if.W_STB = 1'b0; bus_if.W_WE = 1'b0;
        chk("unsel acks", 64'(acks), 64'd0);
        rd("unsel cur", A_CUR, r);
        chk("unsel cur val", 64'(r), 64'd77);
        rd("unsel busy", A_CTRL, r);
        chk("unsel busy val", 64'(r), 64'h0);
        check_log("unsel");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
